// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the instruction-fetch requester and
// the data load/store requester. Only one transaction is in flight at a time.
// Data wins ties, but a streak counter forces a fetch grant after
// MAX_DATA_STREAK back-to-back data grants taken while fetch was waiting.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [31:0]     if_rdata_o,

    input  logic            d_req_i,
    input  logic [XLEN-1:0] d_adr_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [2:0]      d_size_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,

    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    // Fetches are always issued as full words.
    localparam logic [2:0] IF_SIZE = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            pick_d, pick_if;

    logic [XLEN-1:0] mem_adr_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [2:0]      mem_size_q;

    logic            if_rvalid_q;
    logic [31:0]     if_rdata_q;
    logic            d_rvalid_q;
    logic [XLEN-1:0] d_rdata_q;

    // Winner selection: data first, unless fetch has waited through a full streak.
    always_comb begin
        pick_d  = d_req_i && !(if_req_i && (streak_q == STREAK_MAX));
        pick_if = !pick_d && if_req_i;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant in IDLE, return to IDLE once memory acknowledges.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = BUSY_D;
                end else if (pick_if) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grants only from IDLE, suppressed while reset is held so
    // every output reads 0 during reset.
    always_comb begin
        if_gnt_o  = reset_n && (state_q == IDLE) && pick_if;
        d_gnt_o   = reset_n && (state_q == IDLE) && pick_d;
        mem_req_o = (state_q != IDLE);
    end

    // Streak counter update: grows on data grants that bypass a waiting fetch.
    always_comb begin
        streak_d = streak_q;
        if (d_gnt_o) begin
            if (!if_req_i) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (if_gnt_o) begin
            streak_d = '0;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Capture the granted request; fields stay frozen until the next grant so
    // later requester changes cannot disturb the transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_adr_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_size_q  <= 3'b000;
        end else if (d_gnt_o) begin
            mem_adr_q   <= d_adr_i;
            mem_we_q    <= d_we_i;
            mem_wdata_q <= d_wdata_i;
            mem_size_q  <= d_size_i;
        end else if (if_gnt_o) begin
            mem_adr_q   <= if_adr_i;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_size_q  <= IF_SIZE;
        end
    end

    // Response path: one-cycle rvalid pulse after ack, rdata held between pulses.
    // Acks seen in IDLE never reach either requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= (state_q == BUSY_IF) && mem_ack_i;
            d_rvalid_q  <= (state_q == BUSY_D) && mem_ack_i;
            if ((state_q == BUSY_IF) && mem_ack_i) begin
                if_rdata_q <= mem_rdata_i[31:0];
            end
            if ((state_q == BUSY_D) && mem_ack_i) begin
                d_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign mem_adr_o   = mem_adr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_size_o  = mem_size_q;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch-only, data priority, fetch
// anti-starvation, zero-wait memory, mid-transaction reset, spurious ack.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            if_req_i;
    logic [XLEN-1:0] if_adr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [31:0]     if_rdata_o;
    logic            d_req_i;
    logic [XLEN-1:0] d_adr_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_wdata_i;
    logic [2:0]      d_size_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_adr_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [2:0]      mem_size_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;

    // Memory model: manual ack/data, or zero-wait responder returning ~address.
    logic            ack_tie;
    logic            ack_man;
    logic [XLEN-1:0] rdata_man;

    assign mem_ack_i   = ack_tie ? mem_req_o  : ack_man;
    assign mem_rdata_i = ack_tie ? ~mem_adr_o : rdata_man;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .MAX_DATA_STREAK(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_req_i    (if_req_i),
        .if_adr_i    (if_adr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_adr_i     (d_adr_i),
        .d_we_i      (d_we_i),
        .d_wdata_i   (d_wdata_i),
        .d_size_i    (d_size_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_adr_o   (mem_adr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_size_o  (mem_size_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] order;
        int         ng;
        int         exp_ord [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int         nrv;
        logic       exp_g;
        logic       exp_rv;

        reset_n   = 1'b0;
        if_req_i  = 1'b0;
        if_adr_i  = '0;
        d_req_i   = 1'b0;
        d_adr_i   = '0;
        d_we_i    = 1'b0;
        d_wdata_i = '0;
        d_size_i  = 3'b000;
        ack_tie   = 1'b0;
        ack_man   = 1'b0;
        rdata_man = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_adr", mem_adr_o, 0);
        check("rst_if_rvalid", if_rvalid_o, 0);
        check("rst_d_rvalid", d_rvalid_o, 0);
        check("rst_d_rdata", d_rdata_o, 0);
        reset_n = 1'b1;
        next_cycle();

        // 1. Fetch only, ack after three cycles of mem_req_o
        if_req_i = 1'b1;
        if_adr_i = 32'h80;
        settle();
        check("t1_if_gnt", if_gnt_o, 1);
        check("t1_mem_req_c0", mem_req_o, 0);
        next_cycle();
        if_req_i = 1'b0;
        settle();
        check("t1_mem_req_c1", mem_req_o, 1);
        check("t1_mem_adr", mem_adr_o, 32'h80);
        check("t1_mem_we", mem_we_o, 0);
        check("t1_if_gnt_busy", if_gnt_o, 0);
        next_cycle();
        settle();
        check("t1_mem_req_c2", mem_req_o, 1);
        next_cycle();
        ack_man   = 1'b1;
        rdata_man = 32'h00500093;
        settle();
        check("t1_mem_req_c3", mem_req_o, 1);
        check("t1_rvalid_c3", if_rvalid_o, 0);
        next_cycle();
        ack_man = 1'b0;
        settle();
        check("t1_rvalid_c4", if_rvalid_o, 1);
        check("t1_rdata", if_rdata_o, 32'h00500093);
        check("t1_mem_req_c4", mem_req_o, 0);
        next_cycle();
        settle();
        check("t1_rvalid_c5", if_rvalid_o, 0);
        check("t1_rdata_hold", if_rdata_o, 32'h00500093);

        // 2. Simultaneous requests: store first, fetch when the port frees up
        if_req_i  = 1'b1;
        if_adr_i  = 32'h200;
        d_req_i   = 1'b1;
        d_adr_i   = 32'h100;
        d_we_i    = 1'b1;
        d_wdata_i = 32'hDEADBEEF;
        d_size_i  = 3'b010;
        settle();
        check("t2_d_gnt", d_gnt_o, 1);
        check("t2_if_gnt_c0", if_gnt_o, 0);
        next_cycle();
        d_req_i = 1'b0;
        ack_man = 1'b1;
        settle();
        check("t2_mem_adr", mem_adr_o, 32'h100);
        check("t2_mem_we", mem_we_o, 1);
        check("t2_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        check("t2_mem_size", mem_size_o, 3'b010);
        check("t2_if_gnt_busy", if_gnt_o, 0);
        next_cycle();
        ack_man = 1'b0;
        settle();
        check("t2_d_rvalid", d_rvalid_o, 1);
        check("t2_if_gnt_after", if_gnt_o, 1);
        next_cycle();
        if_req_i  = 1'b0;
        ack_man   = 1'b1;
        rdata_man = 32'h00000013;
        settle();
        check("t2_if_mem_adr", mem_adr_o, 32'h200);
        check("t2_if_mem_we", mem_we_o, 0);
        check("t2_d_rvalid_once", d_rvalid_o, 0);
        next_cycle();
        ack_man = 1'b0;
        settle();
        check("t2_if_rvalid", if_rvalid_o, 1);
        check("t2_if_rdata", if_rdata_o, 32'h00000013);
        next_cycle();

        // 3. Starvation bound: both requesters held high, zero-wait memory
        ack_tie  = 1'b1;
        if_req_i = 1'b1;
        if_adr_i = 32'h400;
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_adr_i  = 32'h800;
        order    = '0;
        ng       = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            settle();
            if (d_gnt_o) begin
                order[ng] = 1'b1;
                ng++;
            end else if (if_gnt_o) begin
                order[ng] = 1'b0;
                ng++;
            end
            next_cycle();
        end
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        check("t3_grant_count", ng, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_order_%0d", i), order[i], exp_ord[i]);
        end
        next_cycle();
        next_cycle();

        // 4. Zero-wait memory, back-to-back loads
        nrv = 0;
        for (int c = 0; c <= 12; c++) begin
            d_req_i = (c < 12);
            d_adr_i = 32'h1000 + 32'(4 * (c / 2));
            settle();
            exp_g  = (c < 12) && (c % 2 == 0);
            exp_rv = (c >= 2) && (c % 2 == 0);
            check($sformatf("t4_gnt_c%0d", c), d_gnt_o, exp_g);
            check($sformatf("t4_rvalid_c%0d", c), d_rvalid_o, exp_rv);
            if (d_rvalid_o) begin
                nrv++;
            end
            if (exp_rv) begin
                check($sformatf("t4_rdata_c%0d", c), d_rdata_o, ~(32'h1000 + 32'(4 * (c / 2 - 1))));
            end
            next_cycle();
        end
        check("t4_rvalid_total", nrv, 6);
        ack_tie = 1'b0;
        next_cycle();

        // 5. Reset during BUSY_D
        d_req_i = 1'b1;
        d_adr_i = 32'h500;
        settle();
        check("t5_d_gnt", d_gnt_o, 1);
        next_cycle();
        d_req_i = 1'b0;
        settle();
        check("t5_mem_req_busy", mem_req_o, 1);
        reset_n  = 1'b0;
        if_req_i = 1'b1;
        if_adr_i = 32'h600;
        settle();
        check("t5_rst_mem_req", mem_req_o, 0);
        check("t5_rst_mem_adr", mem_adr_o, 0);
        check("t5_rst_if_gnt", if_gnt_o, 0);
        check("t5_rst_d_rdata", d_rdata_o, 0);
        next_cycle();
        settle();
        check("t5_rst_hold_req", mem_req_o, 0);
        reset_n = 1'b1;
        settle();
        check("t5_if_gnt", if_gnt_o, 1);
        check("t5_no_d_rvalid0", d_rvalid_o, 0);
        next_cycle();
        if_req_i  = 1'b0;
        ack_man   = 1'b1;
        rdata_man = 32'h00000077;
        settle();
        check("t5_mem_adr", mem_adr_o, 32'h600);
        check("t5_no_d_rvalid1", d_rvalid_o, 0);
        next_cycle();
        ack_man = 1'b0;
        settle();
        check("t5_if_rvalid", if_rvalid_o, 1);
        check("t5_if_rdata", if_rdata_o, 32'h00000077);
        check("t5_no_d_rvalid2", d_rvalid_o, 0);
        next_cycle();

        // 6. Spurious ack in IDLE, then address change after grant
        ack_man   = 1'b1;
        rdata_man = 32'h00000BAD;
        settle();
        check("t6_idle_no_gnt", d_gnt_o | if_gnt_o, 0);
        next_cycle();
        ack_man = 1'b0;
        settle();
        check("t6_no_if_rvalid", if_rvalid_o, 0);
        check("t6_no_d_rvalid", d_rvalid_o, 0);
        check("t6_no_mem_req", mem_req_o, 0);
        check("t6_if_rdata_hold", if_rdata_o, 32'h00000077);
        d_req_i   = 1'b1;
        d_adr_i   = 32'h300;
        d_we_i    = 1'b1;
        d_wdata_i = 32'h00001234;
        settle();
        check("t6_d_gnt", d_gnt_o, 1);
        next_cycle();
        d_req_i   = 1'b0;
        d_adr_i   = 32'h400;
        d_wdata_i = 32'h0000FFFF;
        settle();
        check("t6_adr_kept_c1", mem_adr_o, 32'h300);
        check("t6_wdata_kept", mem_wdata_o, 32'h00001234);
        next_cycle();
        ack_man = 1'b1;
        settle();
        check("t6_adr_kept_c2", mem_adr_o, 32'h300);
        next_cycle();
        ack_man = 1'b0;
        settle();
        check("t6_d_rvalid", d_rvalid_o, 1);
        check("t6_mem_req_drop", mem_req_o, 0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
